// File: rtl/accum_int_ctrl.sv
// accum_int_ctrl
//   Consumer end of the time base's ACCUM_INT / TIC pulses. Gathers per-channel
//   accumulator dump pulses between accum_enable strobes and presents a status
//   snapshot to the CPU. It raises a sticky interrupt and timestamps each
//   snapshot with tic_count. It also counts snapshots that were overwritten
//   before the CPU read them.
//
// Ports
//   clk           system clock (40 MHz sample domain)
//   rst           asynchronous, active-high reset
//   accum_enable  1-cycle ACCUM_INT strobe from the time base
//   tic_enable    1-cycle TIC strobe from the time base
//   tic_count     live TIC down-counter value [TS_W]
//   dump          per-channel 1-cycle accumulator dump pulses [NUM_CH]
//   status_rd     1-cycle CPU read / acknowledge strobe
//   accum_int     interrupt request, level, sticky until status_rd
//   status        channels that dumped in the snapshot interval(s) [NUM_CH]
//   tic_flag      a TIC occurred since the last status_rd
//   snap_time     tic_count captured at the latest snapshot [TS_W]
//   ovr_count     saturating count of unread snapshots overwritten [OVR_W]
module accum_int_ctrl #(
   parameter int NUM_CH = 12,
   parameter int TS_W   = 24,
   parameter int OVR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              accum_enable,
   input  logic              tic_enable,
   input  logic [TS_W-1:0]   tic_count,
   input  logic [NUM_CH-1:0] dump,
   input  logic              status_rd,
   output logic              accum_int,
   output logic [NUM_CH-1:0] status,
   output logic              tic_flag,
   output logic [TS_W-1:0]   snap_time,
   output logic [OVR_W-1:0]  ovr_count
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t            state, state_n;
   logic [NUM_CH-1:0] pending, pending_n;
   logic [NUM_CH-1:0] snap;
   logic [NUM_CH-1:0] status_n;
   logic [TS_W-1:0]   snap_time_n;
   logic [OVR_W-1:0]  ovr_count_n;
   logic              tic_flag_n;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // A dump arriving in the same cycle as accum_enable belongs to the snapshot
   // being taken, so it is folded in here rather than left in pending.
   assign snap = pending | dump;

   always_comb begin
      state_n     = state;
      status_n    = status;
      snap_time_n = snap_time;
      ovr_count_n = ovr_count;
      pending_n   = accum_enable ? '0 : (pending | dump);
      // Set wins over clear when both strobes coincide.
      tic_flag_n  = tic_enable ? 1'b1 : (status_rd ? 1'b0 : tic_flag);

      unique case (state)
         ST_IDLE: begin
            if (accum_enable) begin
               state_n     = ST_WAIT;
               status_n    = snap;
               snap_time_n = tic_count;
            end
         end
         ST_WAIT: begin
            if (accum_enable && status_rd) begin
               // The read consumes the old snapshot; the new one replaces it
               // outright and is not an overrun.
               status_n    = snap;
               snap_time_n = tic_count;
            end else if (accum_enable) begin
               status_n    = status | snap;
               snap_time_n = tic_count;
               ovr_count_n = sat_inc(ovr_count);
            end else if (status_rd) begin
               state_n  = ST_IDLE;
               status_n = '0;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // ---- register stage: all outputs registered, one clk after the strobe ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         pending   <= '0;
         status    <= '0;
         snap_time <= '0;
         ovr_count <= '0;
         tic_flag  <= 1'b0;
      end else begin
         state     <= state_n;
         pending   <= pending_n;
         status    <= status_n;
         snap_time <= snap_time_n;
         ovr_count <= ovr_count_n;
         tic_flag  <= tic_flag_n;
      end
   end

   assign accum_int = (state == ST_WAIT);

endmodule
